mem_stage_pipe: RTL

//  Parametrised, stallable MEM stage for the pipelined CPU. Issues loads/stores over a req/ack

---
 rtl/mem_stage_if.sv | 20 ++
 rtl/mem_stage_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage_if : req/ack memory port between the MEM stage and memory
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface
`default_nettype wire

// File: rtl/mem_stage_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage_pipe : stallable MEM stage with req/ack memory port and WB mux
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_stage_pipe #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              valid_in_i,
  input  wire logic [DATA_W-1:0] alu_out_i,
  input  wire logic [DATA_W-1:0] reg1_data_i,
  input  wire logic [DATA_W-1:0] reg2_data_i,
  input  wire logic [DATA_W-1:0] next_pc_i,
  input  wire logic [DATA_W-1:0] set_val_i,
  input  wire logic [15:0]       instr_i,
  input  wire logic              mem_en_i,
  input  wire logic              mem_wr_i,
  input  wire logic              reg_wrt_i,
  input  wire logic [2:0]        reg_wrt_src_i,
  input  wire logic              halt_i,
  output logic                   stall_o,
  mem_stage_if.master            mem,
  output logic                   wb_valid_o,
  output logic                   wb_reg_wrt_o,
  output logic [DATA_W-1:0]      wb_data_o,
  output logic                   err_o,
  output logic                   dump_o
);

  localparam int c_cnt_w = $clog2(MAX_WAIT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MAX_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_HALTED = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                wb_valid_q, wb_valid_d, wb_reg_wrt_q, wb_reg_wrt_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                err_q, err_d, dump_q, dump_d;
  logic [DATA_W-1:0]   op_alu_q, op_alu_d, op_reg1_q, op_reg1_d;
  logic [DATA_W-1:0]   op_npc_q, op_npc_d, op_set_q, op_set_d;
  logic [7:0]          op_imm_q, op_imm_d;
  logic [2:0]          op_src_q, op_src_d;
  logic                op_rw_q, op_rw_d, op_we_q, op_we_d;
  logic [7:0]          unused_instr_hi;

  assign unused_instr_hi = instr_i[15:8];

  function automatic logic [DATA_W-1:0] f_wb_sel(
    input logic [2:0]        src,
    input logic [DATA_W-1:0] rdata, alu, npc, setv, reg1,
    input logic [7:0]        imm
  );
    logic [DATA_W-1:0] rev;
    for (int i = 0; i < DATA_W; i++) rev[i] = reg1[DATA_W-1-i];
    case (src)
      3'd0:    f_wb_sel = rdata;
      3'd1:    f_wb_sel = alu;
      3'd2:    f_wb_sel = npc;
      3'd3:    f_wb_sel = setv;
      3'd4:    f_wb_sel = {{(DATA_W-8){imm[7]}}, imm};
      3'd5:    f_wb_sel = {reg1[DATA_W-9:0], imm};
      3'd6:    f_wb_sel = rev;
      default: f_wb_sel = '0;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wb_valid_d   = 1'b0;
    wb_reg_wrt_d = wb_reg_wrt_q;
    wb_data_d    = wb_data_q;
    err_d        = err_q;
    dump_d       = 1'b0;
    op_alu_d     = op_alu_q;
    op_reg1_d    = op_reg1_q;
    op_npc_d     = op_npc_q;
    op_set_d     = op_set_q;
    op_imm_d     = op_imm_q;
    op_src_d     = op_src_q;
    op_rw_d      = op_rw_q;
    op_we_d      = op_we_q;
    stall_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid_in_i) begin
          if (reg_wrt_i && (reg_wrt_src_i == 3'd7)) begin
            err_d   = 1'b1;
            dump_d  = 1'b1;
            state_d = S_HALTED;
          end else if (halt_i) begin
            wb_valid_d   = 1'b1;
            wb_reg_wrt_d = 1'b0;
            dump_d       = 1'b1;
            state_d      = S_HALTED;
          end else if (mem_en_i) begin
            stall_o     = 1'b1;
            op_alu_d    = alu_out_i;
            op_reg1_d   = reg1_data_i;
            op_npc_d    = next_pc_i;
            op_set_d    = set_val_i;
            op_imm_d    = instr_i[7:0];
            op_src_d    = reg_wrt_src_i;
            op_rw_d     = reg_wrt_i;
            op_we_d     = mem_wr_i;
            mem_req_d   = 1'b1;
            mem_we_d    = mem_wr_i;
            mem_addr_d  = alu_out_i[ADDR_W-1:0];
            mem_wdata_d = reg2_data_i;
            cnt_d       = '0;
            state_d     = S_ACCESS;
          end else begin
            wb_valid_d   = 1'b1;
            wb_reg_wrt_d = reg_wrt_i;
            wb_data_d    = f_wb_sel(reg_wrt_src_i, mem.rdata, alu_out_i, next_pc_i,
                                    set_val_i, reg1_data_i, instr_i[7:0]);
          end
        end
      end
      S_ACCESS: begin
        stall_o = 1'b1;
        // An ack on the last permitted cycle takes priority over the timeout.
        if (mem.ack) begin
          stall_o    = 1'b0;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          wb_valid_d = 1'b1;
          state_d    = S_IDLE;
          if (op_we_q) begin
            wb_reg_wrt_d = 1'b0;
            wb_data_d    = op_alu_q;
          end else begin
            wb_reg_wrt_d = op_rw_q;
            wb_data_d    = f_wb_sel(op_src_q, mem.rdata, op_alu_q, op_npc_q,
                                    op_set_q, op_reg1_q, op_imm_q);
          end
        end else if (cnt_q == c_cnt_last) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
          dump_d    = 1'b1;
          state_d   = S_HALTED;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      S_HALTED: stall_o = 1'b1;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wb_valid_q   <= 1'b0;
      wb_reg_wrt_q <= 1'b0;
      wb_data_q    <= '0;
      err_q        <= 1'b0;
      dump_q       <= 1'b0;
      op_alu_q     <= '0;
      op_reg1_q    <= '0;
      op_npc_q     <= '0;
      op_set_q     <= '0;
      op_imm_q     <= '0;
      op_src_q     <= '0;
      op_rw_q      <= 1'b0;
      op_we_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_reg_wrt_q <= wb_reg_wrt_d;
      wb_data_q    <= wb_data_d;
      err_q        <= err_d;
      dump_q       <= dump_d;
      op_alu_q     <= op_alu_d;
      op_reg1_q    <= op_reg1_d;
      op_npc_q     <= op_npc_d;
      op_set_q     <= op_set_d;
      op_imm_q     <= op_imm_d;
      op_src_q     <= op_src_d;
      op_rw_q      <= op_rw_d;
      op_we_q      <= op_we_d;
    end
  end

  assign mem.req      = mem_req_q;
  assign mem.we       = mem_we_q;
  assign mem.addr     = mem_addr_q;
  assign mem.wdata    = mem_wdata_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_reg_wrt_o = wb_reg_wrt_q;
  assign wb_data_o    = wb_data_q;
  assign err_o        = err_q;
  assign dump_o       = dump_q;

endmodule
`default_nettype wire
